nv_nvdla_sdp_x_op_seq: RTL and testbench
========================================

Name: nv_nvdla_sdp_x_op_seq

Overview:
Operand sequencer for the SDP X-stage integer BN pipeline (ALU → MUL → truncate → ReLU lanes).
- Input: a packed per-lane operand stream from the SDP read-DMA.
- Output: the chn_alu_op and chn_mul_op channels of the X pipeline, each with its own valid/ready.
- Per-channel mode: holds one operand beat and replays it for every element of a surface.
- Per-element mode: passes one operand beat per data beat.
- Counts width/height/channel across a cube and pulses done at the end.

Parameters:
THROUGHPUT, 2, lanes per beat (must match the X pipeline lane count)
OP_DW, 16, operand width per lane

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  reset, synchronous, active-low
op_start  in  1  one-cycle start pulse; ignored unless idle
cfg_per_elem  in  1  1 = per-element operands, 0 = per-channel
cfg_width  in  13  surface width minus 1
cfg_height  in  13  surface height minus 1
cfg_channel  in  13  channel groups minus 1
cfg_alu_src  in  1  1 = ALU operand from memory
cfg_alu_bypass  in  1  ALU stage bypassed
cfg_mul_src  in  1  1 = MUL operand from memory
cfg_mul_bypass  in  1  MUL stage bypassed
op_in_pvld  in  1  DMA operand beat valid
op_in_prdy  out  1  DMA operand beat ready
op_in_pd  in  2*THROUGHPUT*OP_DW  [THROUGHPUT*OP_DW-1:0] = ALU lanes; upper half = MUL lanes
chn_alu_op  out  THROUGHPUT*OP_DW  ALU operand to pipeline
chn_alu_op_pvld  out  1  ALU operand valid
chn_alu_op_prdy  in  1  ALU operand ready
chn_mul_op  out  THROUGHPUT*OP_DW  MUL operand to pipeline
chn_mul_op_pvld  out  1  MUL operand valid
chn_mul_op_prdy  in  1  MUL operand ready
op_busy  out  1  sequencer active
op_done  out  1  one-cycle pulse at cube completion

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rstn is synchronous and active-low.
- Reset values:
  - State = IDLE; all counters 0; op register 0.
  - op_in_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_busy and op_done all 0.
  - chn_alu_op and chn_mul_op = 0.
- Reset mid-operation aborts immediately. No done pulse is produced, and partially delivered operands are dropped.
- Enables: alu_en = cfg_alu_src & ~cfg_alu_bypass; mul_en = cfg_mul_src & ~cfg_mul_bypass. Config is sampled at op_start and held internally until done.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - op_start with alu_en | mul_en → FETCH, op_busy = 1.
  - op_start with neither enabled → DONE. No DMA beats are consumed.
- FETCH: op_in_prdy = 1. On accept, capture op_in_pd, set alu_pend = alu_en and mul_pend = mul_en, then → SEND.
- SEND, output handshake:
  - chn_alu_op_pvld = alu_pend; chn_mul_op_pvld = mul_pend.
  - Each pend flag clears on its own valid & ready. The two channels are independent forks, and either may be accepted first.
  - Output data is stable while its valid is high.
- SEND, element completion: an element completes when every pending flag is clear, or clears in this cycle. On completion, advance w_cnt, wrapping into h_cnt, wrapping into c_cnt.
- SEND, next action after completion:
  - Per-channel mode, not the last element of the surface: re-arm the pend flags with the same data next cycle. No bubble.
  - Per-element mode, or last element of the surface, not last of cube: op_in_prdy = 1 in the completing cycle. If a beat is accepted, capture it, re-arm and stay in SEND (zero bubble). Otherwise → FETCH.
  - Last element of the cube: → DONE. op_in_prdy stays 0.
- DONE: op_done = 1 for exactly one cycle, op_busy = 0, → IDLE.
- Throughput and latency:
  - Steady state is 1 element per cycle with both readies high.
  - First valid appears 1 cycle after the first op_in accept.
- Counter wrap:
  - w_cnt == cfg_width wraps to 0 and increments h_cnt.
  - h_cnt == cfg_height wraps to 0 and increments c_cnt.
  - Last of cube = all three counters at max.
- op_start while busy is ignored.
- Config changes while busy have no effect.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/FETCH/SEND/DONE);
  - THROUGHPUT and OP_DW defaults;
  - the 13-bit dimension width constant;
  - op_in_pd half-split offsets.
- Natural sub-module: nv_nvdla_sdp_x_op_cnt, the W/H/C nested counter with last_surface and last_cube outputs.

Test Plan:
- Per-channel, W=1, H=0, C=1, both enabled, readies high:
  - Beats A then B.
  - ALU sees A,A,B,B and MUL sees the same on consecutive cycles.
  - op_done fires the cycle after the 4th accept. Exactly 2 op_in accepts.
- Per-element, W=3, H=0, C=0, beats 1..4 back-to-back: outputs 1,2,3,4 on 4 consecutive cycles; op_in_prdy has no bubble between beats.
- Fork skew: chn_mul_op_prdy low for 3 cycles while ALU ready.
  - ALU valid drops after 1 cycle; MUL valid is held with stable data.
  - The next element starts only after the MUL accept.
- alu_src=1, mul_bypass=1: chn_mul_op_pvld never asserts; the ALU sequence completes normally.
- Both disabled: op_start gives op_done 1 cycle later with zero op_in_prdy cycles.
- rstn low during SEND with 2 elements outstanding: all valids and op_busy are 0 the next cycle, no op_done. A new op_start then runs cleanly.

Source files
------------

// File: rtl/nv_nvdla_sdp_x_op_seq_pkg.sv
// Shared types and constants for the SDP X-stage operand sequencer.
// Holds the FSM encoding, default lane geometry and the op_in_pd split.
package nv_nvdla_sdp_x_op_seq_pkg;

    localparam int THROUGHPUT_DEF = 2;
    localparam int OP_DW_DEF      = 16;
    localparam int DIM_W          = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } op_state_e;

    // ALU lanes sit in the low half of op_in_pd, MUL lanes in the upper half.
    localparam int ALU_OFF = 0;

    function automatic int mul_off(input int tp, input int dw);
        return tp * dw;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_x_op_cnt.sv
// Nested width/height/channel element counter for one operand cube.
// Flags the last element of a surface and the last element of the cube.
module nv_nvdla_sdp_x_op_cnt
    import nv_nvdla_sdp_x_op_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    input  logic [DIM_W-1:0] channel_i,
    output logic             last_surface_o,
    output logic             last_cube_o
);

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [DIM_W-1:0] c_q, c_d;
    logic             w_last, h_last, c_last;

    assign w_last         = (w_q == width_i);
    assign h_last         = (h_q == height_i);
    assign c_last         = (c_q == channel_i);
    assign last_surface_o = w_last & h_last;
    assign last_cube_o    = w_last & h_last & c_last;

    always_comb begin
        w_d = w_q;
        h_d = h_q;
        c_d = c_q;
        if (clr_i) begin
            w_d = '0;
            h_d = '0;
            c_d = '0;
        end else if (adv_i) begin
            if (w_last) begin
                w_d = '0;
                if (h_last) begin
                    h_d = '0;
                    c_d = c_last ? '0 : c_q + ONE;
                end else begin
                    h_d = h_q + ONE;
                end
            end else begin
                w_d = w_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            w_q <= '0;
            h_q <= '0;
            c_q <= '0;
        end else begin
            w_q <= w_d;
            h_q <= h_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_x_op_seq.sv
// Operand sequencer feeding the ALU/MUL operand channels of the SDP X pipeline.
// Replays one beat per surface (per-channel) or forwards one beat per element.
module nv_nvdla_sdp_x_op_seq
    import nv_nvdla_sdp_x_op_seq_pkg::*;
#(
    parameter int THROUGHPUT = THROUGHPUT_DEF,
    parameter int OP_DW      = OP_DW_DEF
) (
    input  logic                           nvdla_core_clk,
    input  logic                           nvdla_core_rstn,
    input  logic                           op_start,
    input  logic                           cfg_per_elem,
    input  logic [DIM_W-1:0]               cfg_width,
    input  logic [DIM_W-1:0]               cfg_height,
    input  logic [DIM_W-1:0]               cfg_channel,
    input  logic                           cfg_alu_src,
    input  logic                           cfg_alu_bypass,
    input  logic                           cfg_mul_src,
    input  logic                           cfg_mul_bypass,
    input  logic                           op_in_pvld,
    output logic                           op_in_prdy,
    input  logic [2*THROUGHPUT*OP_DW-1:0]  op_in_pd,
    output logic [THROUGHPUT*OP_DW-1:0]    chn_alu_op,
    output logic                           chn_alu_op_pvld,
    input  logic                           chn_alu_op_prdy,
    output logic [THROUGHPUT*OP_DW-1:0]    chn_mul_op,
    output logic                           chn_mul_op_pvld,
    input  logic                           chn_mul_op_prdy,
    output logic                           op_busy,
    output logic                           op_done
);

    localparam int HW     = THROUGHPUT * OP_DW;
    localparam int MUL_LO = mul_off(THROUGHPUT, OP_DW);

    op_state_e          state_q, state_d;
    logic [2*HW-1:0]    op_q, op_d;
    logic               alu_pend_q, alu_pend_d;
    logic               mul_pend_q, mul_pend_d;
    logic               per_elem_q, per_elem_d;
    logic               alu_en_q, alu_en_d;
    logic               mul_en_q, mul_en_d;
    logic [DIM_W-1:0]   width_q, width_d;
    logic [DIM_W-1:0]   height_q, height_d;
    logic [DIM_W-1:0]   channel_q, channel_d;

    logic alu_fire, mul_fire, alu_left, mul_left, elem_done;
    logic cnt_clr, cnt_adv, last_surface, last_cube;
    logic start_alu_en, start_mul_en;

    assign start_alu_en = cfg_alu_src & ~cfg_alu_bypass;
    assign start_mul_en = cfg_mul_src & ~cfg_mul_bypass;

    assign chn_alu_op      = op_q[ALU_OFF +: HW];
    assign chn_mul_op      = op_q[MUL_LO +: HW];
    assign chn_alu_op_pvld = alu_pend_q;
    assign chn_mul_op_pvld = mul_pend_q;
    assign op_busy         = (state_q == ST_FETCH) || (state_q == ST_SEND);
    assign op_done         = (state_q == ST_DONE);

    // The two channels are independent forks; an element is complete once
    // neither has an operand left outstanding after this cycle.
    assign alu_fire  = alu_pend_q & chn_alu_op_prdy;
    assign mul_fire  = mul_pend_q & chn_mul_op_prdy;
    assign alu_left  = alu_pend_q & ~alu_fire;
    assign mul_left  = mul_pend_q & ~mul_fire;
    assign elem_done = (state_q == ST_SEND) & ~alu_left & ~mul_left;

    nv_nvdla_sdp_x_op_cnt u_cnt (
        .clk_i          (nvdla_core_clk),
        .rstn_i         (nvdla_core_rstn),
        .clr_i          (cnt_clr),
        .adv_i          (cnt_adv),
        .width_i        (width_q),
        .height_i       (height_q),
        .channel_i      (channel_q),
        .last_surface_o (last_surface),
        .last_cube_o    (last_cube)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        alu_pend_d = alu_left;
        mul_pend_d = mul_left;
        per_elem_d = per_elem_q;
        alu_en_d   = alu_en_q;
        mul_en_d   = mul_en_q;
        width_d    = width_q;
        height_d   = height_q;
        channel_d  = channel_q;
        cnt_clr    = 1'b0;
        cnt_adv    = 1'b0;
        op_in_prdy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    per_elem_d = cfg_per_elem;
                    alu_en_d   = start_alu_en;
                    mul_en_d   = start_mul_en;
                    width_d    = cfg_width;
                    height_d   = cfg_height;
                    channel_d  = cfg_channel;
                    cnt_clr    = 1'b1;
                    state_d    = (start_alu_en | start_mul_en) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                op_in_prdy = 1'b1;
                if (op_in_pvld) begin
                    op_d       = op_in_pd;
                    alu_pend_d = alu_en_q;
                    mul_pend_d = mul_en_q;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (elem_done) begin
                    cnt_adv = 1'b1;
                    if (last_cube) begin
                        state_d = ST_DONE;
                    end else if (!per_elem_q && !last_surface) begin
                        alu_pend_d = alu_en_q;
                        mul_pend_d = mul_en_q;
                    end else begin
                        // Accepting the next beat in the completing cycle keeps
                        // back-to-back elements bubble free.
                        op_in_prdy = 1'b1;
                        if (op_in_pvld) begin
                            op_d       = op_in_pd;
                            alu_pend_d = alu_en_q;
                            mul_pend_d = mul_en_q;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            alu_pend_q <= 1'b0;
            mul_pend_q <= 1'b0;
            per_elem_q <= 1'b0;
            alu_en_q   <= 1'b0;
            mul_en_q   <= 1'b0;
            width_q    <= '0;
            height_q   <= '0;
            channel_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            alu_pend_q <= alu_pend_d;
            mul_pend_q <= mul_pend_d;
            per_elem_q <= per_elem_d;
            alu_en_q   <= alu_en_d;
            mul_en_q   <= mul_en_d;
            width_q    <= width_d;
            height_q   <= height_d;
            channel_q  <= channel_d;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_x_op_seq.sv
// Self-checking bench: randomized cubes against a queue-based operand model.
module tb_nv_nvdla_sdp_x_op_seq;
    import nv_nvdla_sdp_x_op_seq_pkg::*;

    localparam int TP = 2;
    localparam int DW = 16;
    localparam int HW = TP * DW;

    logic            clk = 1'b0;
    logic            rstn;
    logic            op_start;
    logic            cfg_per_elem;
    logic [DIM_W-1:0] cfg_width, cfg_height, cfg_channel;
    logic            cfg_alu_src, cfg_alu_bypass, cfg_mul_src, cfg_mul_bypass;
    logic            op_in_pvld, op_in_prdy;
    logic [2*HW-1:0] op_in_pd;
    logic [HW-1:0]   chn_alu_op, chn_mul_op;
    logic            chn_alu_op_pvld, chn_alu_op_prdy;
    logic            chn_mul_op_pvld, chn_mul_op_prdy;
    logic            op_busy, op_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nv_nvdla_sdp_x_op_seq #(.THROUGHPUT(TP), .OP_DW(DW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_start        (op_start),
        .cfg_per_elem    (cfg_per_elem),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .cfg_channel     (cfg_channel),
        .cfg_alu_src     (cfg_alu_src),
        .cfg_alu_bypass  (cfg_alu_bypass),
        .cfg_mul_src     (cfg_mul_src),
        .cfg_mul_bypass  (cfg_mul_bypass),
        .op_in_pvld      (op_in_pvld),
        .op_in_prdy      (op_in_prdy),
        .op_in_pd        (op_in_pd),
        .chn_alu_op      (chn_alu_op),
        .chn_alu_op_pvld (chn_alu_op_pvld),
        .chn_alu_op_prdy (chn_alu_op_prdy),
        .chn_mul_op      (chn_mul_op),
        .chn_mul_op_pvld (chn_mul_op_pvld),
        .chn_mul_op_prdy (chn_mul_op_prdy),
        .op_busy         (op_busy),
        .op_done         (op_done)
    );

    task automatic idle_inputs();
        op_start        = 1'b0;
        op_in_pvld      = 1'b0;
        op_in_pd        = '0;
        chn_alu_op_prdy = 1'b1;
        chn_mul_op_prdy = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        cfg_per_elem = 0; cfg_width = 0; cfg_height = 0; cfg_channel = 0;
        cfg_alu_src = 0; cfg_alu_bypass = 0; cfg_mul_src = 0; cfg_mul_bypass = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({op_in_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_busy, op_done} !== 5'b0 ||
            chn_alu_op !== '0 || chn_mul_op !== '0) begin
            bad++;
            $display("FAIL reset_state: ctl=%b alu=%h mul=%h expected all zero",
                     {op_in_prdy, chn_alu_op_pvld, chn_mul_op_pvld, op_busy, op_done},
                     chn_alu_op, chn_mul_op);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Runs one cube. mode 0: readies/pvld always high, 1: random, 2: MUL skewed.
    task automatic run_cube(input bit pe, input bit as, input bit ab, input bit ms,
                            input bit mb, input int w, input int h, input int c,
                            input int mode, input string nm);
        logic [HW-1:0] ba[$], bm[$], ea[$], em[$];
        logic [HW-1:0] ha, hm;
        bit ae, me, hold_a, hold_m;
        int nel, nb, bi, done_k, last_fire, prdy_cyc, a_vc, m_vc, busy_err, budget, idx;
        ae = as & ~ab;
        me = ms & ~mb;
        nel = (w + 1) * (h + 1) * (c + 1);
        nb = (ae | me) ? (pe ? nel : c + 1) : 0;
        for (int i = 0; i < nb; i++) begin
            ba.push_back({$urandom, $urandom});
            bm.push_back({$urandom, $urandom});
        end
        if (ae | me)
            for (int e = 0; e < nel; e++) begin
                idx = pe ? e : e / ((w + 1) * (h + 1));
                if (ae) ea.push_back(ba[idx]);
                if (me) em.push_back(bm[idx]);
            end
        bi = 0; done_k = -1; last_fire = 0; prdy_cyc = 0; a_vc = 0; m_vc = 0;
        busy_err = 0; hold_a = 0; hold_m = 0; ha = '0; hm = '0;
        budget = nel * 24 + 40;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (k == 0) begin
                op_start = 1'b1;
                cfg_per_elem = pe; cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
                cfg_channel = DIM_W'(c); cfg_alu_src = as; cfg_alu_bypass = ab;
                cfg_mul_src = ms; cfg_mul_bypass = mb;
            end else begin
                op_start = (k == 2) && (nel >= 2) && (ae | me);
                cfg_per_elem = 1'($urandom); cfg_width = DIM_W'($urandom_range(0, 7));
                cfg_height = DIM_W'($urandom_range(0, 7));
                cfg_channel = DIM_W'($urandom_range(0, 7));
                {cfg_alu_src, cfg_alu_bypass, cfg_mul_src, cfg_mul_bypass} = 4'($urandom);
            end
            case (mode)
                0: begin chn_alu_op_prdy = 1; chn_mul_op_prdy = 1; end
                1: begin chn_alu_op_prdy = 1'($urandom); chn_mul_op_prdy = 1'($urandom); end
                default: begin chn_alu_op_prdy = 1; chn_mul_op_prdy = (k % 5) >= 3; end
            endcase
            op_in_pvld = (bi < nb) && (mode == 0 || $urandom_range(0, 3) != 0);
            op_in_pd   = (bi < nb) ? {bm[bi], ba[bi]} : {$urandom, $urandom};
            #1;
            if (op_done) begin
                done_k = k;
                break;
            end
            if (k >= 1 && op_busy !== (ae | me)) busy_err++;
            if (op_in_prdy) prdy_cyc++;
            if (op_in_pvld && op_in_prdy) bi++;
            if (hold_a) begin
                total++;
                if (!(chn_alu_op_pvld && chn_alu_op === ha)) begin
                    bad++;
                    $display("FAIL %s alu_hold k=%0d: vld=%b op=%h required vld=1 op=%h",
                             nm, k, chn_alu_op_pvld, chn_alu_op, ha);
                end
            end
            if (hold_m) begin
                total++;
                if (!(chn_mul_op_pvld && chn_mul_op === hm)) begin
                    bad++;
                    $display("FAIL %s mul_hold k=%0d: vld=%b op=%h required vld=1 op=%h",
                             nm, k, chn_mul_op_pvld, chn_mul_op, hm);
                end
            end
            hold_a = chn_alu_op_pvld && !chn_alu_op_prdy; ha = chn_alu_op;
            hold_m = chn_mul_op_pvld && !chn_mul_op_prdy; hm = chn_mul_op;
            if (chn_alu_op_pvld) a_vc++;
            if (chn_mul_op_pvld) m_vc++;
            if (chn_alu_op_pvld && chn_alu_op_prdy) begin
                last_fire = k;
                total++;
                if (ea.size() == 0) begin
                    bad++;
                    $display("FAIL %s alu_extra k=%0d: op=%h required no beat", nm, k, chn_alu_op);
                end else if (chn_alu_op !== ea[0]) begin
                    bad++;
                    $display("FAIL %s alu_data k=%0d: op=%h required %h", nm, k, chn_alu_op, ea[0]);
                end
                if (ea.size() != 0) void'(ea.pop_front());
            end
            if (chn_mul_op_pvld && chn_mul_op_prdy) begin
                last_fire = k;
                total++;
                if (em.size() == 0) begin
                    bad++;
                    $display("FAIL %s mul_extra k=%0d: op=%h required no beat", nm, k, chn_mul_op);
                end else if (chn_mul_op !== em[0]) begin
                    bad++;
                    $display("FAIL %s mul_data k=%0d: op=%h required %h", nm, k, chn_mul_op, em[0]);
                end
                if (em.size() != 0) void'(em.pop_front());
            end
        end
        total++;
        if (done_k < 0) begin
            bad++;
            $display("FAIL %s done_timeout: no op_done within %0d cycles", nm, budget);
        end else begin
            total++;
            if (ea.size() != 0 || em.size() != 0 || bi != nb) begin
                bad++;
                $display("FAIL %s completeness: alu_left=%0d mul_left=%0d accepts=%0d required 0 0 %0d",
                         nm, ea.size(), em.size(), bi, nb);
            end
            total++;
            if (done_k != ((ae | me) ? last_fire + 1 : 1)) begin
                bad++;
                $display("FAIL %s done_cycle: got k=%0d required k=%0d", nm, done_k,
                         (ae | me) ? last_fire + 1 : 1);
            end
            total++;
            if ((!ae && a_vc != 0) || (!me && m_vc != 0) || busy_err != 0) begin
                bad++;
                $display("FAIL %s disabled_or_busy: alu_vld=%0d mul_vld=%0d busy_err=%0d required 0 on disabled/err",
                         nm, a_vc, m_vc, busy_err);
            end
            if (mode == 0) begin
                total++;
                if (done_k != ((ae | me) ? nel + 2 : 1) || prdy_cyc != nb) begin
                    bad++;
                    $display("FAIL %s throughput: done_k=%0d prdy_cycles=%0d required %0d %0d",
                             nm, done_k, prdy_cyc, (ae | me) ? nel + 2 : 1, nb);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (op_done !== 1'b0 || op_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_one_shot: done=%b busy=%b required 0 0", nm, op_done, op_busy);
        end
    endtask

    task automatic test_fork_skew();
        logic [HW-1:0] a, m;
        a = {$urandom, $urandom};
        m = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            op_start = (k == 0);
            if (k == 0) begin
                cfg_per_elem = 0; cfg_width = 1; cfg_height = 0; cfg_channel = 0;
                cfg_alu_src = 1; cfg_alu_bypass = 0; cfg_mul_src = 1; cfg_mul_bypass = 0;
            end
            op_in_pvld = (k == 1);
            op_in_pd = {m, a};
            chn_alu_op_prdy = 1'b1;
            chn_mul_op_prdy = !(k >= 2 && k <= 4);
            #1;
            if (k == 3 || k == 4) begin
                total++;
                if (chn_alu_op_pvld !== 1'b0 || chn_mul_op_pvld !== 1'b1 || chn_mul_op !== m) begin
                    bad++;
                    $display("FAIL fork_skew_hold k=%0d: alu_vld=%b mul_vld=%b mul=%h required 0 1 %h",
                             k, chn_alu_op_pvld, chn_mul_op_pvld, chn_mul_op, m);
                end
            end
            if (k == 6) begin
                total++;
                if (chn_alu_op_pvld !== 1'b1 || chn_mul_op_pvld !== 1'b1 || chn_alu_op !== a) begin
                    bad++;
                    $display("FAIL fork_skew_next k=%0d: alu_vld=%b mul_vld=%b alu=%h required 1 1 %h",
                             k, chn_alu_op_pvld, chn_mul_op_pvld, chn_alu_op, a);
                end
            end
            if (k == 7) begin
                total++;
                if (op_done !== 1'b1) begin
                    bad++;
                    $display("FAIL fork_skew_done k=%0d: done=%b required 1", k, op_done);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op_start = (k == 0);
            cfg_per_elem = 1; cfg_width = 3; cfg_height = 0; cfg_channel = 0;
            cfg_alu_src = 1; cfg_alu_bypass = 0; cfg_mul_src = 1; cfg_mul_bypass = 0;
            op_in_pvld = (k == 1);
            op_in_pd = {$urandom, $urandom, $urandom, $urandom};
            chn_alu_op_prdy = 1'b0;
            chn_mul_op_prdy = 1'b0;
        end
        #1;
        total++;
        if (chn_alu_op_pvld !== 1'b1 || chn_mul_op_pvld !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup: alu_vld=%b mul_vld=%b required 1 1",
                     chn_alu_op_pvld, chn_mul_op_pvld);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({chn_alu_op_pvld, chn_mul_op_pvld, op_busy, op_done, op_in_prdy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_abort: vld_a/vld_m/busy/done/prdy=%b required 00000",
                     {chn_alu_op_pvld, chn_mul_op_pvld, op_busy, op_done, op_in_prdy});
        end
        rstn = 1'b1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (op_done || op_busy) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: %0d active cycles after abort required 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        // directed scenarios
        run_cube(0, 1, 0, 1, 0, 1, 0, 1, 0, "per_chan_AABB");
        run_cube(1, 1, 0, 1, 0, 3, 0, 0, 0, "per_elem_b2b");
        test_fork_skew();
        run_cube(1, 1, 0, 1, 1, 2, 1, 1, 0, "alu_only_elem");
        run_cube(0, 1, 0, 1, 1, 1, 1, 2, 1, "alu_only_chan");
        run_cube(0, 0, 0, 1, 0, 2, 0, 1, 1, "mul_only_chan");
        run_cube(1, 0, 0, 1, 1, 3, 3, 3, 0, "both_disabled");
        run_cube(0, 1, 1, 0, 0, 0, 0, 0, 1, "both_disabled_b");
        test_reset_mid();
        run_cube(1, 1, 0, 1, 0, 2, 1, 0, 1, "after_reset");
        // randomized cubes
        for (int t = 0; t < 12; t++)
            run_cube(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom), 1'($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2), "random");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
